blinker_button_conditioner: RTL and testbench
=============================================

// Module: blinker_button_conditioner
// PURPOSE
//  Upstream input stage for the blinker top-level: conditions a raw, bouncy, asynchronous push-button.
//  Synchronises it into the system1000 domain and debounces it.
//  Produces a clean level, one-cycle press/release pulses, and a press-toggled mode bit.
//  The mode bit (mode_q) drives the blinker's 1-bit input.
// PARAMETERS
//  SYNC_STAGES      2      synchroniser flops on btn_raw (legal >= 2)
//  DEBOUNCE_CYCLES  20000  consecutive differing samples needed to accept a change (legal >= 2)
//  CNT_W            15     counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  ACTIVE_LOW       0      1: btn_raw is inverted before synchronisation (pressed = 0 on pin)
// PORTS
//  system1000       in   1  clock
//  system1000_rstn  in   1  asynchronous reset, active low
//  btn_raw          in   1  raw button pin, asynchronous to system1000, may bounce
//  btn_level        out  1  debounced pressed level (1 = pressed)
//  btn_press        out  1  one-cycle pulse on accepted 0->1 of btn_level
//  btn_release      out  1  one-cycle pulse on accepted 1->0 of btn_level
//  mode_q           out  1  toggles on every btn_press; feeds blinker input
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All sync flops = 0 (post-inversion value).
//   - state = STABLE, cnt = 0.
//   - btn_level = btn_press = btn_release = mode_q = 0.
//  Sampling:
//   - p = btn_raw ^ ACTIVE_LOW feeds a SYNC_STAGES-deep flop chain.
//   - s = last flop. Only s is used by the FSM; btn_raw never reaches logic directly.
//  FSM (2 states), L = btn_level:
//   STABLE: s == L -> stay, cnt = 0.
//           s != L -> CHECK, cnt = 1.
//   CHECK:  s == L -> STABLE, cnt = 0. Bounce is discarded; no output change.
//           s != L and cnt == DEBOUNCE_CYCLES-1 -> commit:
//             - L <= s, STABLE, cnt = 0.
//             - pulse btn_press if s = 1, btn_release if s = 0.
//           s != L otherwise -> cnt <= cnt + 1 (cannot exceed DEBOUNCE_CYCLES-1; no wrap).
//  Outputs:
//   - All outputs are registered.
//   - Pulses are high for exactly the one cycle after the commit edge; 0 otherwise.
//   - mode_q flips on the same edge that asserts btn_press.
//   - btn_press and btn_release are never high together.
//  Latency: if edge k is the first edge at which sync flop 0 captures the new value,
//   and the value is held, btn_level and the pulse update at edge
//   k + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
//  Boundaries:
//   - Glitch shorter than DEBOUNCE_CYCLES samples at s: no output activity.
//   - A single s sample equal to L during CHECK restarts the whole count.
//   - A press held indefinitely yields one btn_press only. No auto-repeat.
//   - Reset asserted mid-CHECK aborts the count. No pulse is emitted.
//     After release, a still-pressed button is re-accepted after the full latency.
//   - Release while a press is pending (still in CHECK) cancels the press.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless stated)
//  1 Reset, btn_raw=0 for 20 cyc -> all outputs 0 throughout.
//  2 btn_raw 0->1 sampled at edge 10, held -> btn_level=1 and btn_press=1 at edge 15 only;
//    mode_q=1 from edge 15.
//  3 Bounce: btn_raw=1 for 2 cyc, 0 for 1, 1 held, first 1 at edge 10 ->
//    no pulse before edge 18; btn_press at edge 18.
//  4 Press held 100 cyc, then release -> one btn_press, then one btn_release 5 edges after release;
//    two full presses -> mode_q back to 0.
//  5 Reset asserted 2 cyc into CHECK, button held -> outputs 0 immediately;
//    btn_press 5 edges after rstn deasserts.
//  6 ACTIVE_LOW=1, btn_raw held 1 -> idle, no pulses; btn_raw 1->0 held -> btn_press after 5 edges.

Source files
------------

// File: rtl/blinker_button_conditioner.sv
// -----------------------------------------------------------------------------
// blinker_button_conditioner
//
// Input stage for the blinker top level. It takes a raw, bouncy push-button pin
// that is asynchronous to system1000 and produces:
//   - a synchronised, debounced pressed level,
//   - one-cycle press / release pulses on each accepted change,
//   - a mode bit that toggles on every accepted press (drives the blinker input).
//
// Ports
//   system1000       in   clock
//   system1000_rstn  in   asynchronous reset, active low (release is synchronous
//                         in the sense that all state restarts from idle)
//   btn_raw          in   raw button pin, may bounce, asynchronous
//   btn_level        out  debounced pressed level (1 = pressed)
//   btn_press        out  one-cycle pulse on an accepted 0->1 of btn_level
//   btn_release      out  one-cycle pulse on an accepted 1->0 of btn_level
//   mode_q           out  toggles on every btn_press
//
// Parameters
//   SYNC_STAGES      synchroniser depth on btn_raw (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing samples needed to accept a change (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   ACTIVE_LOW       1: pin is inverted before synchronisation (pressed = 0)
// -----------------------------------------------------------------------------
module blinker_button_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic system1000,
  input  logic system1000_rstn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic mode_q
);

  localparam logic             INVERT   = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE,
    ST_CHECK
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser. The pin is normalised to "1 = pressed" before the first flop
  // so the reset value of every stage means "released".
  // ---------------------------------------------------------------------------
  logic                   btn_p;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   btn_s;

  assign btn_p = btn_raw ^ INVERT;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_p};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM. STABLE waits for the synchronised sample to differ from the
  // accepted level; CHECK counts consecutive differing samples. Any sample that
  // agrees with the level again drops back to STABLE, discarding the count.
  // ---------------------------------------------------------------------------
  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               level_q;
  logic               level_d;
  logic               press_q;
  logic               press_d;
  logic               release_q;
  logic               release_d;
  logic               mode_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    mode_d    = mode_q;

    case (state_q)
      ST_STABLE: begin
        if (btn_s != level_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      ST_CHECK: begin
        if (btn_s == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Commit: this is the DEBOUNCE_CYCLES-th consecutive differing sample.
          state_d   = ST_STABLE;
          cnt_d     = '0;
          level_d   = btn_s;
          press_d   = btn_s;
          release_d = ~btn_s;
          if (btn_s) begin
            mode_d = ~mode_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      mode_q    <= mode_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_blinker_button_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for blinker_button_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Two instances: one active-high, one active-low driven with the inverted pin,
// so both must behave identically to the same reference model.
// -----------------------------------------------------------------------------
module tb_blinker_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_raw_n;
  logic lvl1, prs1, rel1, mode1;
  logic lvl2, prs2, rel2, mode2;

  int checks = 0;
  int errors = 0;
  int press_cnt = 0;
  int release_cnt = 0;

  assign btn_raw_n = ~btn_raw;

  always #5 clk = ~clk;

  blinker_button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3), .ACTIVE_LOW(0)
  ) dut_hi (
    .system1000(clk), .system1000_rstn(rstn), .btn_raw(btn_raw),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .mode_q(mode1)
  );

  blinker_button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3), .ACTIVE_LOW(1)
  ) dut_lo (
    .system1000(clk), .system1000_rstn(rstn), .btn_raw(btn_raw_n),
    .btn_level(lvl2), .btn_press(prs2), .btn_release(rel2), .mode_q(mode2)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the pin is seen through a SYNC-sample delay line; a change
  // is accepted once DEB consecutive delayed samples differ from the level.
  // ---------------------------------------------------------------------------
  bit hist[$];
  int run_len;
  bit m_level, m_press, m_release, m_mode, m_s;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      run_len   = 0;
      m_level   = 1'b0;
      m_press   = 1'b0;
      m_release = 1'b0;
      m_mode    = 1'b0;
    end else begin
      m_s       = hist.pop_front();
      m_press   = 1'b0;
      m_release = 1'b0;
      if (m_s != m_level) begin
        run_len++;
        if (run_len == DEB) begin
          m_level   = m_s;
          m_press   = m_s;
          m_release = !m_s;
          if (m_s) m_mode = !m_mode;
          run_len   = 0;
        end
      end else begin
        run_len = 0;
      end
      hist.push_back(btn_raw);
    end
  end

  always @(negedge clk) begin
    check("model_hi", {4'b0, lvl1, prs1, rel1, mode1}, {4'b0, m_level, m_press, m_release, m_mode});
    check("model_lo", {4'b0, lvl2, prs2, rel2, mode2}, {4'b0, m_level, m_press, m_release, m_mode});
  end

  always @(posedge clk) begin
    #1;
    if (prs1) press_cnt++;
    if (rel1) release_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk); #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  // pat[i] is driven before edge i; the pulse must appear only after edge pulse_at.
  task automatic run_pattern(input string nm, input logic [15:0] pat, input int n,
                             input int pulse_at, input bit is_press);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_raw = pat[i];
      @(posedge clk); #1;
      if (is_press) check(nm, {6'b0, prs1, prs2}, (i == pulse_at) ? 8'h03 : 8'h00);
      else          check(nm, {6'b0, rel1, rel2}, (i == pulse_at) ? 8'h03 : 8'h00);
      if (i == pulse_at)
        check({nm, "_level"}, {6'b0, lvl1, lvl2}, is_press ? 8'h03 : 8'h00);
    end
  endtask

  typedef struct {
    bit raw;
    int cycles;
    int exp_press;
    int exp_release;
    bit exp_level;
    bit exp_mode;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, r0, seg_len;
    bit seg_val;

    tbl[0]  = '{1'b0, 20,  0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2,   0, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 10,  0, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3,   0, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 10,  0, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 100, 1, 0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 3,   0, 0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 10,  0, 0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 10,  0, 1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8,   1, 0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8,   0, 1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    // Idle after reset: everything stays low.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle", {lvl1, prs1, rel1, mode1, lvl2, prs2, rel2, mode2}, 8'h00);
    end

    // Clean press, held: one pulse at capture edge + 5, mode set.
    run_pattern("press1", 16'hFFFF, 8, 5, 1'b1);
    check("mode_after_press1", {6'b0, mode1, mode2}, 8'h03);
    p0 = press_cnt;
    repeat (100) @(negedge clk);
    check("no_autorepeat", 8'(press_cnt - p0), 8'd0);
    run_pattern("release1", 16'h0000, 8, 5, 1'b0);
    run_pattern("press2", 16'hFFFF, 8, 5, 1'b1);
    check("mode_after_press2", {6'b0, mode1, mode2}, 8'h00);
    run_pattern("release2", 16'h0000, 8, 5, 1'b0);

    // Bounce 1,1,0 then held: count restarts at the last rising sample.
    run_pattern("bounce", 16'hFFFB, 11, 8, 1'b1);
    check("mode_after_bounce", {6'b0, mode1, mode2}, 8'h03);
    run_pattern("release3", 16'h0000, 8, 5, 1'b0);

    // Reset two cycles into CHECK, button kept pressed.
    @(negedge clk);
    btn_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("pre_reset", {6'b0, prs1, prs2}, 8'h00);
    end
    @(negedge clk); #2 rstn = 1'b0;
    #1 check("reset_outputs", {lvl1, prs1, rel1, mode1, lvl2, prs2, rel2, mode2}, 8'h00);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("post_reset_press", {6'b0, prs1, prs2}, (i == 5) ? 8'h03 : 8'h00);
    end
    @(negedge clk);
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven vectors from a fresh reset.
    do_reset();
    repeat (5) @(negedge clk);
    foreach (tbl[i]) begin
      p0 = press_cnt;
      r0 = release_cnt;
      btn_raw = tbl[i].raw;
      repeat (tbl[i].cycles) @(negedge clk);
      check($sformatf("vec%0d_press", i),   8'(press_cnt - p0),   8'(tbl[i].exp_press));
      check($sformatf("vec%0d_release", i), 8'(release_cnt - r0), 8'(tbl[i].exp_release));
      check($sformatf("vec%0d_state", i), {4'b0, lvl1, mode1, lvl2, mode2},
            {4'b0, tbl[i].exp_level, tbl[i].exp_mode, tbl[i].exp_level, tbl[i].exp_mode});
    end

    // Randomised segments, mostly short (bounce) with occasional long holds
    // and occasional resets; checked every cycle against the model.
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end
      seg_val = 1'($urandom_range(0, 1));
      seg_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 20))
                                             : int'($urandom_range(1, 5));
      @(negedge clk);
      btn_raw = seg_val;
      repeat (seg_len - 1) @(negedge clk);
    end
    btn_raw = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
